snake_motion_ctrl: RTL

Per-frame motion scheduler for the two snake heads drawn by the colour/background renderer. It latches direction keys for both players from the 16-bit keycode and steps both head positions in lock-step every STEP_FRAMES frames. It rejects 180° reversals, detects wall and head-to-head collisions, and sequences the game through IDLE/RUN/OVER. Its outputs drive the renderer's snake position inputs and the direction-sprite mux selects directly.

---
 rtl/snake_motion_if.sv | 31 +++
 rtl/snake_motion_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_motion_if.sv
// Control/position bundle between the game front-end and the snake motion scheduler.
`default_nettype none

interface snake_motion_if;
    logic        frame_tick;
    logic        start;
    logic [15:0] keycode;
    logic [9:0]  snakeX_pos;
    logic [9:0]  snakeY_pos;
    logic [9:0]  snake2X_pos;
    logic [9:0]  snake2Y_pos;
    logic [1:0]  motionFlag;
    logic [1:0]  motionFlag1;
    logic        step_pulse;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output frame_tick, start, keycode,
        input  snakeX_pos, snakeY_pos, snake2X_pos, snake2Y_pos,
        input  motionFlag, motionFlag1, step_pulse, game_over, winner
    );

    modport slave (
        input  frame_tick, start, keycode,
        output snakeX_pos, snakeY_pos, snake2X_pos, snake2Y_pos,
        output motionFlag, motionFlag1, step_pulse, game_over, winner
    );
endinterface

`default_nettype wire

// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl: frame-paced lock-step mover for two snake heads with
// key latching, reversal rejection, wall/head collision and IDLE/RUN/OVER sequencing.
`default_nettype none

module snake_motion_ctrl #(
    parameter int STEP_PX     = 24,
    parameter int STEP_FRAMES = 8,
    parameter int X_MIN       = 12,
    parameter int X_MAX       = 627,
    parameter int Y_MIN       = 12,
    parameter int Y_MAX       = 467,
    parameter int P1_X0       = 120,
    parameter int P1_Y0       = 240,
    parameter int P2_X0       = 516,
    parameter int P2_Y0       = 240
) (
    input  logic          Clk,
    input  logic          Reset,
    snake_motion_if.slave bus
);

    localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic signed [10:0] STEP_S = 11'(STEP_PX);
    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
    localparam logic signed [11:0] HIT_S  = 12'(STEP_PX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       p1x_q, p1y_q, p2x_q, p2y_q;
    logic [9:0]       p1x_d, p1y_d, p2x_d, p2y_d;
    logic [1:0]       dir1_q, dir2_q, dir1_d, dir2_d;
    logic [1:0]       pend1_q, pend2_q, pend1_d, pend2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             over_q, over_d;
    logic [1:0]       winner_q, winner_d;

    // {valid, direction}
    function automatic logic [2:0] decode_p1(input logic [7:0] k);
        case (k)
            8'h1A:   return {1'b1, DIR_UP};
            8'h04:   return {1'b1, DIR_LEFT};
            8'h16:   return {1'b1, DIR_DOWN};
            8'h07:   return {1'b1, DIR_RIGHT};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] decode_p2(input logic [7:0] k);
        case (k)
            8'h52:   return {1'b1, DIR_UP};
            8'h50:   return {1'b1, DIR_LEFT};
            8'h51:   return {1'b1, DIR_DOWN};
            8'h4F:   return {1'b1, DIR_RIGHT};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic signed [10:0] next_x(input logic [9:0] x, input logic [1:0] d);
        case (d)
            DIR_LEFT:  return $signed({1'b0, x}) - STEP_S;
            DIR_RIGHT: return $signed({1'b0, x}) + STEP_S;
            default:   return $signed({1'b0, x});
        endcase
    endfunction

    function automatic logic signed [10:0] next_y(input logic [9:0] y, input logic [1:0] d);
        case (d)
            DIR_UP:   return $signed({1'b0, y}) - STEP_S;
            DIR_DOWN: return $signed({1'b0, y}) + STEP_S;
            default:  return $signed({1'b0, y});
        endcase
    endfunction

    function automatic logic signed [11:0] abs_diff(input logic signed [10:0] a,
                                                    input logic signed [10:0] b);
        logic signed [11:0] d;
        d = {a[10], a} - {b[10], b};
        return (d < 0) ? -d : d;
    endfunction

    logic [2:0]        key1_lo, key1_hi, key2_lo, key2_hi, key1, key2;
    logic signed [10:0] nx1, ny1, nx2, ny2;
    logic              crash1, crash2, heads_hit, restart;

    assign key1_lo = decode_p1(bus.keycode[7:0]);
    assign key1_hi = decode_p1(bus.keycode[15:8]);
    assign key2_lo = decode_p2(bus.keycode[7:0]);
    assign key2_hi = decode_p2(bus.keycode[15:8]);
    assign key1    = key1_lo[2] ? key1_lo : key1_hi;
    assign key2    = key2_lo[2] ? key2_lo : key2_hi;

    // The step moves along the pending direction, which is committed in the same cycle.
    assign nx1 = next_x(p1x_q, pend1_q);
    assign ny1 = next_y(p1y_q, pend1_q);
    assign nx2 = next_x(p2x_q, pend2_q);
    assign ny2 = next_y(p2y_q, pend2_q);

    assign crash1 = (nx1 < XMIN_S) || (nx1 > XMAX_S) || (ny1 < YMIN_S) || (ny1 > YMAX_S);
    assign crash2 = (nx2 < XMIN_S) || (nx2 > XMAX_S) || (ny2 < YMIN_S) || (ny2 > YMAX_S);
    assign heads_hit = (abs_diff(nx1, nx2) < HIT_S) && (abs_diff(ny1, ny2) < HIT_S);

    assign restart = bus.start && (state_q != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            p1x_q    <= 10'(P1_X0);
            p1y_q    <= 10'(P1_Y0);
            p2x_q    <= 10'(P2_X0);
            p2y_q    <= 10'(P2_Y0);
            dir1_q   <= DIR_RIGHT;
            dir2_q   <= DIR_LEFT;
            pend1_q  <= DIR_RIGHT;
            pend2_q  <= DIR_LEFT;
            cnt_q    <= '0;
            step_q   <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            p1x_q    <= p1x_d;
            p1y_q    <= p1y_d;
            p2x_q    <= p2x_d;
            p2y_q    <= p2y_d;
            dir1_q   <= dir1_d;
            dir2_q   <= dir2_d;
            pend1_q  <= pend1_d;
            pend2_q  <= pend2_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p1x_d    = p1x_q;
        p1y_d    = p1y_q;
        p2x_d    = p2x_q;
        p2y_d    = p2y_q;
        dir1_d   = dir1_q;
        dir2_d   = dir2_q;
        pend1_d  = pend1_q;
        pend2_d  = pend2_q;
        cnt_d    = cnt_q;
        step_d   = 1'b0;
        over_d   = over_q;
        winner_d = winner_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!bus.start) begin
                    // Reversal is judged against the committed heading only.
                    if (key1[2] && (key1[1:0] != (dir1_q ^ 2'd2)))
                        pend1_d = key1[1:0];
                    if (key2[2] && (key2[1:0] != (dir2_q ^ 2'd2)))
                        pend2_d = key2[1:0];
                    if (bus.frame_tick) begin
                        if (cnt_q != CNT_LAST) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            cnt_d  = '0;
                            step_d = 1'b1;
                            dir1_d = pend1_q;
                            dir2_d = pend2_q;
                            if (crash1 || crash2) begin
                                state_d  = OVER;
                                over_d   = 1'b1;
                                winner_d = (crash1 && crash2) ? 2'd3 : (crash1 ? 2'd2 : 2'd1);
                            end else begin
                                p1x_d = nx1[9:0];
                                p1y_d = ny1[9:0];
                                p2x_d = nx2[9:0];
                                p2y_d = ny2[9:0];
                                if (heads_hit) begin
                                    state_d  = OVER;
                                    over_d   = 1'b1;
                                    winner_d = 2'd3;
                                end
                            end
                        end
                    end
                end
            end
            OVER: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restart) begin
            state_d  = RUN;
            p1x_d    = 10'(P1_X0);
            p1y_d    = 10'(P1_Y0);
            p2x_d    = 10'(P2_X0);
            p2y_d    = 10'(P2_Y0);
            dir1_d   = DIR_RIGHT;
            dir2_d   = DIR_LEFT;
            pend1_d  = DIR_RIGHT;
            pend2_d  = DIR_LEFT;
            cnt_d    = '0;
            step_d   = 1'b0;
            over_d   = 1'b0;
            winner_d = 2'd0;
        end
    end

    assign bus.snakeX_pos  = p1x_q;
    assign bus.snakeY_pos  = p1y_q;
    assign bus.snake2X_pos = p2x_q;
    assign bus.snake2Y_pos = p2y_q;
    assign bus.motionFlag  = dir1_q;
    assign bus.motionFlag1 = dir2_q;
    assign bus.step_pulse  = step_q;
    assign bus.game_over   = over_q;
    assign bus.winner      = winner_q;

endmodule

`default_nettype wire
